// File: rtl/rgb_to_gray.sv
// rtl/rgb_to_gray.sv - camera RGB byte stream to 8-bit gray pixel converter
// Optional round-to-nearest conversion is enabled by defining RGB_TO_GRAY_ROUND_EN.
module rgb_to_gray #(
    parameter int N = 450,
    parameter int M = 600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       GS_enable,
    input  logic       cam_valid,
    input  logic [7:0] cam_data,
    output logic       cam_ready,
    output logic [7:0] data_out,
    output logic       GS_valid,
    output logic       GS_done
);

    localparam int TOTAL = N * M;
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(TOTAL - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CAP_R = 3'd1,
        CAP_G = 3'd2,
        CAP_B = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] pix_cnt_nxt;
    logic [7:0]       r_q;
    logic [7:0]       g_q;
    logic [7:0]       b_q;
    logic             byte_take;
    logic             abort;
    logic             load_r;
    logic             load_g;
    logic             load_b;
    logic [7:0]       b_src;
    logic [15:0]      gray_sum;

    assign byte_take = cam_valid && cam_ready;
    // Dropping the enable outranks any byte offered in the same cycle.
    assign abort  = (state != IDLE) && !GS_enable;
    assign load_r = (state == CAP_R) && byte_take && !abort;
    assign load_g = (state == CAP_G) && byte_take && !abort;
    assign load_b = (state == CAP_B) && byte_take && !abort;

    // The blue byte is consumed straight from the bus so the result is ready on entry to EMIT.
    assign b_src = load_b ? cam_data : b_q;

    // Weights sum to 256, so the worst case (255 on every channel, plus rounding) stays under 2^16.
    always_comb begin
        gray_sum = (16'd77 * {8'h00, r_q}) + (16'd150 * {8'h00, g_q}) + (16'd29 * {8'h00, b_src});
`ifdef RGB_TO_GRAY_ROUND_EN
        gray_sum = gray_sum + 16'd128;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pix_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pix_cnt <= pix_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pix_cnt_nxt = pix_cnt;
        if (abort) begin
            state_nxt   = IDLE;
            pix_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (GS_enable) begin
                        state_nxt   = CAP_R;
                        pix_cnt_nxt = '0;
                    end
                end
                CAP_R: if (byte_take) state_nxt = CAP_G;
                CAP_G: if (byte_take) state_nxt = CAP_B;
                CAP_B: if (byte_take) state_nxt = EMIT;
                EMIT: begin
                    if (pix_cnt == LAST_PIX) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt   = CAP_R;
                        pix_cnt_nxt = pix_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state_nxt   = IDLE;
                    pix_cnt_nxt = '0;
                end
                default: begin
                    state_nxt   = IDLE;
                    pix_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        cam_ready = 1'b0;
        GS_valid  = 1'b0;
        GS_done   = 1'b0;
        case (state)
            CAP_R, CAP_G, CAP_B: cam_ready = 1'b1;
            EMIT:                GS_valid  = 1'b1;
            DONE:                GS_done   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= 8'h00;
            g_q      <= 8'h00;
            b_q      <= 8'h00;
            data_out <= 8'h00;
        end else begin
            if (load_r) r_q <= cam_data;
            if (load_g) g_q <= cam_data;
            if (load_b) begin
                b_q      <= cam_data;
                data_out <= gray_sum[15:8];
            end
        end
    end

endmodule
